eth_rx_frame_parser: RTL and testbench

Parametrised next-generation GMII receive frame parser. It sits directly behind the GMII receive pins, ahead of the collision-detect stage and the switch MAC-learning table. It tracks the frame with a state machine, captures DA/SA/EtherType, folds SA into a configurable-width hash for the learning table, checks FCS and length, and reports a per-frame status. It also forwards a fixed-latency delayed copy of the GMII stream to the collision-detect stage.

---
 rtl/eth_rx_pkg.sv | 43 ++++
 rtl/eth_rx_frame_parser_if.sv | 43 ++++
 rtl/crc32_d8.sv | 23 ++
 rtl/eth_rx_frame_parser.sv | 198 +++++++++++++++++++
 tb/tb_eth_rx_frame_parser.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/eth_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_pkg
// Description : Shared types and constants for the GMII receive frame parser.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DA       = 3'd2,
        ST_SA       = 3'd3,
        ST_TYPE     = 3'd4,
        ST_PAYLOAD  = 3'd5,
        ST_DROP     = 3'd6
    } state_e;

    localparam logic [7:0]  c_PREAMBLE     = 8'h55;
    localparam logic [7:0]  c_SFD          = 8'hD5;

    localparam logic [31:0] c_CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] c_CRC_INIT     = 32'hFFFFFFFF;
    // Residue expressed MSB-first; the reflected register is bit-reversed before comparing.
    localparam logic [31:0] c_CRC_RESIDUE  = 32'hC704DD7B;

    localparam int          c_ERR_RUNT     = 0;
    localparam int          c_ERR_GIANT    = 1;
    localparam int          c_ERR_CRC      = 2;
    localparam int          c_ERR_RXER     = 3;

    localparam logic [13:0] c_LEN_SAT      = 14'h3FFF;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_parser_if
// Description : GMII receive inputs and parsed-frame result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_rx_frame_parser_if #(
    parameter int pHASH_W = 14
);
    logic               i_rx_dv;
    logic               i_rx_er;
    logic [7:0]         i_rx_d;
    logic               i_show_sa;

    logic [2:0]         o_fsm_state;
    logic               o_fsm_state_changed;
    logic               o_rx_dv_d;
    logic               o_rx_er_d;
    logic [7:0]         o_rx_d_d;
    logic [47:0]        o_da;
    logic [47:0]        o_sa;
    logic [15:0]        o_ethertype;
    logic [pHASH_W-1:0] o_sa_hash;
    logic               o_new_sa;
    logic               o_frame_done;
    logic [3:0]         o_frame_err;
    logic [13:0]        o_frame_len;

    modport master (
        output i_rx_dv, i_rx_er, i_rx_d, i_show_sa,
        input  o_fsm_state, o_fsm_state_changed, o_rx_dv_d, o_rx_er_d, o_rx_d_d,
               o_da, o_sa, o_ethertype, o_sa_hash, o_new_sa,
               o_frame_done, o_frame_err, o_frame_len
    );

    modport slave (
        input  i_rx_dv, i_rx_er, i_rx_d, i_show_sa,
        output o_fsm_state, o_fsm_state_changed, o_rx_dv_d, o_rx_er_d, o_rx_d_d,
               o_da, o_sa, o_ethertype, o_sa_hash, o_new_sa,
               o_frame_done, o_frame_err, o_frame_len
    );
endinterface
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module      : crc32_d8
// Description : Byte-wide combinational CRC-32 (reflected) next-state logic.
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    localparam logic [31:0] c_POLY_REFL = bitrev32(c_CRC_POLY);

    always_comb begin
        crc_o = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_o = crc_o[0] ? ((crc_o >> 1) ^ c_POLY_REFL) : (crc_o >> 1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/eth_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_parser
// Description : GMII receive frame parser: header capture, SA hash, FCS/length
//               checks, per-frame status and a fixed-latency GMII copy.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_parser
    import eth_rx_pkg::*;
#(
    parameter int pHASH_W    = 14,
    parameter int pDELAY     = 4,
    parameter int pMIN_LEN   = 64,
    parameter int pMAX_LEN   = 1518,
    parameter int pCHECK_FCS = 1
) (
    input  logic                   i_rx_clk,
    input  logic                   i_rst,
    eth_rx_frame_parser_if.slave   bus
);
    localparam int          c_NSLICE  = (48 + pHASH_W - 1) / pHASH_W;
    localparam int          c_PAD_W   = c_NSLICE * pHASH_W;
    localparam logic [13:0] c_MIN_LEN = 14'(pMIN_LEN);
    localparam logic [13:0] c_MAX_LEN = 14'(pMAX_LEN);

    state_e               state_q, state_d;
    logic                 changed_q;
    logic [13:0]          len_q;
    logic [31:0]          crc_q;
    logic                 rxer_q;
    logic [47:0]          da_q, sa_q;
    logic [15:0]          type_q;
    logic [pHASH_W-1:0]   hash_q;
    logic                 new_sa_q;
    logic                 frame_done_q;
    logic [3:0]           frame_err_q;
    logic [13:0]          frame_len_q;
    logic [9:0]           dly_q [pDELAY];

    logic                 w_body;
    logic                 w_sfd;
    logic [31:0]          w_crc_next;
    logic [47:0]          w_sa_next;
    logic [c_PAD_W-1:0]   w_sa_pad;
    logic [pHASH_W-1:0]   w_hash;
    logic [3:0]           w_err;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (bus.i_rx_d),
        .crc_o  (w_crc_next)
    );

    assign w_body = (state_q == ST_DA) || (state_q == ST_SA) ||
                    (state_q == ST_TYPE) || (state_q == ST_PAYLOAD);
    assign w_sfd  = (state_q == ST_PREAMBLE) && bus.i_rx_dv && (bus.i_rx_d == c_SFD);
    assign w_sa_next = {sa_q[39:0], bus.i_rx_d};

    always_comb begin
        w_sa_pad = c_PAD_W'(w_sa_next);
        w_hash   = '0;
        for (int s = 0; s < c_NSLICE; s++) begin
            w_hash = w_hash ^ w_sa_pad[s*pHASH_W +: pHASH_W];
        end
    end

    always_comb begin
        w_err              = 4'b0000;
        w_err[c_ERR_RXER]  = rxer_q | bus.i_rx_er;
        w_err[c_ERR_CRC]   = (pCHECK_FCS != 0) && (bitrev32(crc_q) != c_CRC_RESIDUE);
        w_err[c_ERR_GIANT] = len_q > c_MAX_LEN;
        w_err[c_ERR_RUNT]  = (len_q < c_MIN_LEN) || (len_q < 14'd14);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_dv) begin
                    state_d = (bus.i_rx_d == c_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!bus.i_rx_dv)                  state_d = ST_IDLE;
                else if (bus.i_rx_d == c_SFD)      state_d = ST_DA;
                else if (bus.i_rx_d != c_PREAMBLE) state_d = ST_DROP;
            end
            ST_DA: begin
                if (!bus.i_rx_dv)         state_d = ST_IDLE;
                else if (len_q == 14'd5)  state_d = ST_SA;
            end
            ST_SA: begin
                if (!bus.i_rx_dv)         state_d = ST_IDLE;
                else if (len_q == 14'd11) state_d = ST_TYPE;
            end
            ST_TYPE: begin
                if (!bus.i_rx_dv)         state_d = ST_IDLE;
                else if (len_q == 14'd13) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD, ST_DROP: begin
                if (!bus.i_rx_dv)         state_d = ST_IDLE;
            end
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_rx_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            changed_q <= (state_d != state_q);
        end
    end

    always_ff @(posedge i_rx_clk) begin
        if (i_rst) begin
            len_q        <= '0;
            crc_q        <= c_CRC_INIT;
            rxer_q       <= 1'b0;
            da_q         <= '0;
            sa_q         <= '0;
            type_q       <= '0;
            hash_q       <= '0;
            new_sa_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= '0;
            frame_len_q  <= '0;
        end else begin
            new_sa_q     <= 1'b0;
            frame_done_q <= 1'b0;
            if (w_sfd) begin
                len_q       <= '0;
                crc_q       <= c_CRC_INIT;
                rxer_q      <= 1'b0;
                frame_err_q <= '0;
                frame_len_q <= '0;
            end else if (w_body) begin
                if (bus.i_rx_er) begin
                    rxer_q <= 1'b1;
                end
                if (bus.i_rx_dv) begin
                    crc_q <= w_crc_next;
                    if (len_q != c_LEN_SAT) begin
                        len_q <= len_q + 14'd1;
                    end
                    case (state_q)
                        ST_DA:   da_q   <= {da_q[39:0], bus.i_rx_d};
                        ST_SA: begin
                            sa_q <= w_sa_next;
                            if (len_q == 14'd11) begin
                                hash_q   <= w_hash;
                                new_sa_q <= bus.i_show_sa;
                            end
                        end
                        ST_TYPE: type_q <= {type_q[7:0], bus.i_rx_d};
                        default: ;
                    endcase
                end else begin
                    frame_done_q <= 1'b1;
                    frame_err_q  <= w_err;
                    frame_len_q  <= len_q;
                end
            end
        end
    end

    // Raw GMII copy, independent of parser state.
    always_ff @(posedge i_rx_clk) begin
        if (i_rst) begin
            for (int i = 0; i < pDELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= {bus.i_rx_dv, bus.i_rx_er, bus.i_rx_d};
            for (int i = 1; i < pDELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign bus.o_fsm_state         = state_q;
    assign bus.o_fsm_state_changed = changed_q;
    assign bus.o_rx_dv_d           = dly_q[pDELAY-1][9];
    assign bus.o_rx_er_d           = dly_q[pDELAY-1][8];
    assign bus.o_rx_d_d            = dly_q[pDELAY-1][7:0];
    assign bus.o_da                = da_q;
    assign bus.o_sa                = sa_q;
    assign bus.o_ethertype         = type_q;
    assign bus.o_sa_hash           = hash_q;
    assign bus.o_new_sa            = new_sa_q;
    assign bus.o_frame_done        = frame_done_q;
    assign bus.o_frame_err         = frame_err_q;
    assign bus.o_frame_len         = frame_len_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_frame_parser
// Description : Randomized self-checking bench for eth_rx_frame_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_frame_parser;
    localparam int HASH_W  = 14;
    localparam int DLY     = 4;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_rx_frame_parser_if #(.pHASH_W(HASH_W)) bus ();

    eth_rx_frame_parser #(
        .pHASH_W    (HASH_W),
        .pDELAY     (DLY),
        .pMIN_LEN   (MIN_LEN),
        .pMAX_LEN   (MAX_LEN),
        .pCHECK_FCS (1)
    ) dut (
        .i_rx_clk (clk),
        .i_rst    (rst),
        .bus      (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0, nsa_cnt = 0, chg_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ethernet FCS of a byte list (value whose LSB byte goes on the wire first).
    function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'd0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [HASH_W-1:0] fold(input logic [47:0] sa);
        logic [HASH_W-1:0] h = '0;
        for (int i = 0; i < 48; i++) h[i % HASH_W] = h[i % HASH_W] ^ sa[i];
        return h;
    endfunction

    // Delay-line reference: history of sampled inputs.
    logic [9:0] hist[$];
    bit armed = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            for (int i = 0; i < DLY; i++) hist.push_back(10'd0);
            armed = 1'b1;
        end else if (armed) begin
            hist.push_back({bus.i_rx_dv, bus.i_rx_er, bus.i_rx_d});
            if (hist.size() > 64) hist.delete(0);
        end
        #1;
        if (armed)
            check_val("delay_line", {bus.o_rx_dv_d, bus.o_rx_er_d, bus.o_rx_d_d}, hist[hist.size()-DLY]);
    end

    always @(negedge clk) begin
        if (armed && !rst) begin
            done_cnt += int'(bus.o_frame_done);
            nsa_cnt  += int'(bus.o_new_sa);
            chg_cnt  += int'(bus.o_fsm_state_changed);
        end
    end

    task automatic send_byte(input logic dv, input logic er, input logic [7:0] d);
        bus.i_rx_dv = dv;
        bus.i_rx_er = er;
        bus.i_rx_d  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int blen, input bit show, input int corrupt,
                              input int er_at, input logic [47:0] sa_in);
        logic [7:0]  body[$];
        logic [7:0]  data[$];
        logic [31:0] fcs, fcs_rx;
        logic [47:0] exp_da, exp_sa;
        logic [15:0] exp_type;
        logic [3:0]  exp_err;
        int          exp_len, npre;
        bit          crc_bad;

        for (int i = 0; i < 6; i++) body.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) body.push_back(sa_in[47-8*i -: 8]);
        while (body.size() < blen - 4) body.push_back(8'($urandom));
        fcs = fcs_of(body);
        for (int i = 0; i < 4; i++) body.push_back(fcs[8*i +: 8]);
        if (corrupt >= 0) body[corrupt] = ~body[corrupt];

        for (int i = 0; i < blen - 4; i++) data.push_back(body[i]);
        fcs_rx  = {body[blen-1], body[blen-2], body[blen-3], body[blen-4]};
        crc_bad = (fcs_of(data) != fcs_rx);
        exp_da = '0; exp_sa = '0;
        for (int i = 0; i < 6; i++) exp_da = {exp_da[39:0], body[i]};
        for (int i = 6; i < 12; i++) exp_sa = {exp_sa[39:0], body[i]};
        exp_type = {body[12], body[13]};
        exp_len  = (blen > 16383) ? 16383 : blen;
        exp_err  = {er_at >= 0, crc_bad, exp_len > MAX_LEN, exp_len < MIN_LEN};

        done_cnt = 0; nsa_cnt = 0; chg_cnt = 0;
        bus.i_show_sa = show;
        npre = $urandom_range(1, 7);
        for (int i = 0; i < npre; i++) begin
            send_byte(1'b1, 1'b0, 8'h55);
            if (i == 0) check_val("state_preamble", bus.o_fsm_state, 3'd1);
        end
        send_byte(1'b1, 1'b0, 8'hD5);
        check_val("state_da", bus.o_fsm_state, 3'd2);
        for (int i = 0; i < blen; i++) begin
            send_byte(1'b1, i == er_at, body[i]);
            if (i == 5) begin
                check_val("da", bus.o_da, exp_da);
                check_val("state_sa", bus.o_fsm_state, 3'd3);
            end
            if (i == 11) begin
                check_val("sa", bus.o_sa, exp_sa);
                check_val("sa_hash", bus.o_sa_hash, fold(exp_sa));
                check_val("new_sa", bus.o_new_sa, show);
                check_val("state_type", bus.o_fsm_state, 3'd4);
            end
            if (i == 13) begin
                check_val("ethertype", bus.o_ethertype, exp_type);
                check_val("state_payload", bus.o_fsm_state, 3'd5);
            end
        end
        send_byte(1'b0, 1'b0, 8'h00);
        check_val("frame_done", bus.o_frame_done, 1'b1);
        check_val("frame_err", bus.o_frame_err, exp_err);
        check_val("frame_len", bus.o_frame_len, 14'(exp_len));
        check_val("state_idle", bus.o_fsm_state, 3'd0);
        send_byte(1'b0, 1'b0, 8'h00);
        check_val("done_pulse_end", bus.o_frame_done, 1'b0);
        check_val("len_hold", bus.o_frame_len, 14'(exp_len));
        check_val("done_count", done_cnt, 1);
        check_val("new_sa_count", nsa_cnt, int'(show));
        check_val("state_changes", chg_cnt, 6);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int blen, cor, era;
        bus.i_rx_dv = 1'b0; bus.i_rx_er = 1'b0; bus.i_rx_d = 8'h00; bus.i_show_sa = 1'b0;
        rst = 1'b1;
        repeat (3) send_byte(1'b0, 1'b0, 8'h00);
        check_val("rst_state", bus.o_fsm_state, 3'd0);
        check_val("rst_changed", bus.o_fsm_state_changed, 1'b0);
        check_val("rst_da", bus.o_da, 48'd0);
        check_val("rst_sa", bus.o_sa, 48'd0);
        check_val("rst_type", bus.o_ethertype, 16'd0);
        check_val("rst_hash", bus.o_sa_hash, '0);
        check_val("rst_new_sa", bus.o_new_sa, 1'b0);
        check_val("rst_done", bus.o_frame_done, 1'b0);
        check_val("rst_err", bus.o_frame_err, 4'd0);
        check_val("rst_len", bus.o_frame_len, 14'd0);
        rst = 1'b0;
        send_byte(1'b0, 1'b0, 8'h00);

        send_frame(64,   1'b1, -1, -1, 48'h001122334455);
        send_frame(64,   1'b1, 30, -1, 48'h001122334455);
        send_frame(40,   1'b0, -1, -1, 48'h001122334455);
        send_frame(1600, 1'b1, -1, -1, {16'($urandom), 32'($urandom)});
        send_frame(64,   1'b0, -1, -1, 48'h001122334455);
        send_frame(100,  1'b1, -1, 50, {16'($urandom), 32'($urandom)});
        for (int n = 0; n < 6; n++) begin
            blen = $urandom_range(20, 300);
            cor  = ($urandom_range(0, 2) == 0) ? $urandom_range(14, blen - 5) : -1;
            era  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, blen - 1) : -1;
            send_frame(blen, 1'($urandom), cor, era, {16'($urandom), 32'($urandom)});
        end

        // Reset in the middle of a payload while dv stays high.
        done_cnt = 0;
        bus.i_show_sa = 1'b0;
        repeat (7) send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) send_byte(1'b1, 1'b0, 8'h33);
        rst = 1'b1;
        send_byte(1'b1, 1'b0, 8'h11);
        rst = 1'b0;
        check_val("midrst_state", bus.o_fsm_state, 3'd0);
        check_val("midrst_da", bus.o_da, 48'd0);
        check_val("midrst_sa", bus.o_sa, 48'd0);
        check_val("midrst_len", bus.o_frame_len, 14'd0);
        check_val("midrst_done", bus.o_frame_done, 1'b0);
        send_byte(1'b1, 1'b0, 8'h11);
        check_val("midrst_drop", bus.o_fsm_state, 3'd6);
        for (int i = 0; i < 5; i++) send_byte(1'b1, 1'b0, 8'h11);
        check_val("drop_hold", bus.o_fsm_state, 3'd6);
        send_byte(1'b0, 1'b0, 8'h00);
        check_val("drop_exit", bus.o_fsm_state, 3'd0);
        send_byte(1'b0, 1'b0, 8'h00);
        check_val("midrst_no_done", done_cnt, 0);

        send_frame(64, 1'b1, -1, -1, {16'($urandom), 32'($urandom)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
